fcpu_uart_tx: RTL
=================

FCPU_UART_TX -- requirements
Module: fcpu_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port ck_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to send.
REQ-006 SHALL have port tx_valid  input  1  tx_data is offered.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port tx_busy  output  1  frame in progress or FIFO non-empty.
REQ-009 SHALL have port uart_rxd_out  output  1  serial line to host, idle high, registered.

Function
REQ-010 SHALL accept a byte on a rising edge where tx_valid and tx_ready are both 1; tx_ready SHALL equal not-full, with no dependence on tx_valid.
REQ-011 SHALL ignore tx_valid while tx_ready is 0; no byte lost, no byte duplicated.
REQ-012 SHALL frame each byte as: start bit 0, 8 data bits LSB first, optional parity (REQ-024), stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty (pop on that edge); START->DATA, DATA->DATA for bits 0..6, DATA->PARITY or STOP after bit 7, PARITY->STOP, each after CLKS_PER_BIT cycles.
REQ-014 SHALL, at end of STOP, go to START directly if FIFO non-empty (no idle gap between frames), else to IDLE.
REQ-015 SHALL drive start bit on uart_rxd_out exactly 2 rising edges after the accepting edge when idle with FIFO empty.
REQ-016 SHALL hold uart_rxd_out at 1 in IDLE.
REQ-017 SHALL allow a FIFO write and pop on the same edge at any occupancy, including full (pop frees the slot only from the next cycle; tx_ready stays 0 that cycle).
REQ-018 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, distinguishing full from empty with one extra pointer bit.
REQ-019 SHALL deassert tx_busy on the cycle after the last stop-bit cycle when FIFO is empty.
REQ-020 SHALL size the baud counter as $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1.

Reset
REQ-021 SHALL, while ck_rst=0, force uart_rxd_out=1, tx_ready=0, tx_busy=0, state=IDLE, FIFO empty, counters 0, asynchronously.
REQ-022 SHALL, on reset mid-frame, abort the frame immediately (line high) and discard all queued bytes.
REQ-023 SHALL assert tx_ready on the first rising edge after ck_rst deasserts.

Configuration
REQ-024 SHALL, with macro FCPU_UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of 8 data bits) between bit 7 and stop; without it, PARITY state SHALL be absent and frame length SHALL be 10 bits.

Structure
REQ-025 SHALL place the state enum (uart_tx_state_t) and default constants UART_CLKS_PER_BIT and UART_FIFO_DEPTH in fcpu_pkg.
REQ-026 SHALL implement the FIFO as sub-module fcpu_uart_fifo (synchronous, first-word-fall-through, registered full/empty).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
REQ-027 Single byte 0xA5 after reset -> line low at edge+2, then bits 1,0,1,0,0,1,0,1, stop 1, each 4 cycles; 40 cycles total (44 with parity, parity bit 0).
REQ-028 Burst 0x00,0xFF,0x55,0x3C,0x81 with tx_valid held -> tx_ready drops after 5th accept until first pop; all 5 frames back-to-back, no idle gap, correct order.
REQ-029 Push while full and frame ending -> same-edge pop, push blocked that cycle, accepted next cycle; no loss/duplication.
REQ-030 ck_rst=0 during DATA bit 3 of 0x0F with 2 queued -> uart_rxd_out=1 immediately; after release line stays idle, tx_busy=0.
REQ-031 Default CLKS_PER_BIT=104, byte 0x41 -> each bit 104 cycles, frame 1040 cycles; host-side UART model decodes 'A'.
REQ-032 Continuous random traffic, 1000 bytes, random tx_valid -> scoreboard matches serial-decoded stream exactly.

Source files
------------

// File: rtl/fcpu_pkg.sv
// Shared types and default constants for the fcpu UART transmitter.
// FCPU_UART_TX_PARITY_EN adds the PARITY state to the frame sequencer.
package fcpu_pkg;

    localparam int UART_CLKS_PER_BIT = 104;
    localparam int UART_FIFO_DEPTH   = 16;

`ifdef FCPU_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } uart_tx_state_t;
`endif

endpackage

// File: rtl/fcpu_uart_fifo.sv
// First-word-fall-through transmit FIFO with registered empty and ready flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fcpu_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             ck_rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty_q, empty_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    // A pop while full only frees the slot for the next cycle: push is gated by the registered ready.
    always_comb begin
        push     = wr_en && ready_q;
        pop      = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        ready_d  = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_ff @(posedge clk or negedge ck_rst) begin
        if (!ck_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_ptr_q[AW-1:0]];
    assign wr_ready = ready_q;
    assign empty    = empty_q;

endmodule

// File: rtl/fcpu_uart_tx.sv
// Buffered 8N1 UART transmitter; FCPU_UART_TX_PARITY_EN selects 8E1 framing.
// The line register follows the sequencer state one cycle later, so frames start two edges after acceptance.
module fcpu_uart_tx
    import fcpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       ck_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       uart_rxd_out
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    uart_tx_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;

    logic             fifo_ready;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_rd_data;
    logic             bit_end;

    fcpu_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .ck_rst   (ck_rst),
        .wr_data  (tx_data),
        .wr_en    (tx_valid),
        .wr_ready (fifo_ready),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_rd_data),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        bit_end  = (cnt_q == CNT_MAX);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rd_data;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef FCPU_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef FCPU_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_rd_data;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_q[bit_q];
`ifdef FCPU_UART_TX_PARITY_EN
            PARITY:  txd_d = ^data_q;
`endif
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) || !fifo_empty || (tx_valid && fifo_ready);
    end

    always_ff @(posedge clk or negedge ck_rst) begin
        if (!ck_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_ready     = fifo_ready;
    assign tx_busy      = busy_q;
    assign uart_rxd_out = txd_q;

endmodule
